// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- bundle between decode, hazard unit, write-back and the
// ID/EX pipeline register.
//   master : drives stall/flush, id_* decode fields and the wb_* write-back
//            port; observes the registered ex_* fields.
//   slave  : the ID/EX register itself (consumes id_*/wb_*, produces ex_*).
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // hazard control
    logic                  stall;
    logic                  flush;
    // decode side
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]            id_rs1, id_rs2, id_rd;
    logic                  id_reg_write, id_mem_read, id_mem_write;
    logic                  id_alu_src, id_branch, id_jump;
    logic [1:0]            id_mem_to_reg;
    logic [3:0]            id_alu_ctrl;
    // write-back port (same cycle as the register-file read)
    logic                  wb_reg_write;
    logic [4:0]            wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    // execute side
    logic                  ex_valid;
    logic [DATA_WIDTH-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]            ex_rs1, ex_rs2, ex_rd;
    logic                  ex_reg_write, ex_mem_read, ex_mem_write;
    logic                  ex_alu_src, ex_branch, ex_jump;
    logic [1:0]            ex_mem_to_reg;
    logic [3:0]            ex_alu_ctrl;

    modport master (
        output stall, flush, id_valid, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_mem_write,
               id_alu_src, id_branch, id_jump, id_mem_to_reg, id_alu_ctrl,
               wb_reg_write, wb_rd, wb_data,
        input  ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch,
               ex_jump, ex_mem_to_reg, ex_alu_ctrl
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rd1, id_rd2, id_imm,
               id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_mem_write,
               id_alu_src, id_branch, id_jump, id_mem_to_reg, id_alu_ctrl,
               wb_reg_write, wb_rd, wb_data,
        output ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch,
               ex_jump, ex_mem_to_reg, ex_alu_ctrl
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with stall hold, flush bubble and
// write-back-to-decode bypass on the two register operands.
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset
//   bus       : id_ex_stage_if.slave (stall/flush, id_*, wb_* in; ex_* out)
//   stall_cnt : (ID_EX_PERF_CNT_EN only) saturating count of valid stall edges
//   flush_cnt : (ID_EX_PERF_CNT_EN only) saturating count of flush edges
// Build option: define ID_EX_PERF_CNT_EN to add the hazard counters.
// Edge priority: reset > flush > stall > load. All outputs are registered.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  alu_src;
        logic                  branch;
        logic                  jump;
        logic [1:0]            mem_to_reg;
        logic [3:0]            alu_ctrl;
    } stage_t;

    stage_t r_ex;
    stage_t w_load;
    logic   w_fwd1, w_fwd2;

    // Register-file write in the same cycle as the read: the read port still
    // returns the old value, so take the write-back data instead. x0 is never
    // forwarded since it is hard-wired to zero.
    assign w_fwd1 = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs1);
    assign w_fwd2 = bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs2);

    always_comb begin
        w_load       = '0;
        w_load.valid = bus.id_valid;
        w_load.pc    = bus.id_pc;
        w_load.rd1   = w_fwd1 ? bus.wb_data : bus.id_rd1;
        w_load.rd2   = w_fwd2 ? bus.wb_data : bus.id_rd2;
        w_load.imm   = bus.id_imm;
        w_load.rs1   = bus.id_rs1;
        w_load.rs2   = bus.id_rs2;
        w_load.rd    = bus.id_rd;
        // Control only travels with a real instruction; data fields are kept
        // even for an invalid slot.
        if (bus.id_valid) begin
            w_load.reg_write  = bus.id_reg_write;
            w_load.mem_read   = bus.id_mem_read;
            w_load.mem_write  = bus.id_mem_write;
            w_load.alu_src    = bus.id_alu_src;
            w_load.branch     = bus.id_branch;
            w_load.jump       = bus.id_jump;
            w_load.mem_to_reg = bus.id_mem_to_reg;
            w_load.alu_ctrl   = bus.id_alu_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)         r_ex <= '0;
        else if (bus.flush) r_ex <= '0;      // bubble wins over stall
        else if (!bus.stall) r_ex <= w_load;
        // stall: hold, no late bypass into the held entry
    end

    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_pc         = r_ex.pc;
    assign bus.ex_rd1        = r_ex.rd1;
    assign bus.ex_rd2        = r_ex.rd2;
    assign bus.ex_imm        = r_ex.imm;
    assign bus.ex_rs1        = r_ex.rs1;
    assign bus.ex_rs2        = r_ex.rs2;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.ex_reg_write  = r_ex.reg_write;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_alu_src    = r_ex.alu_src;
    assign bus.ex_branch     = r_ex.branch;
    assign bus.ex_jump       = r_ex.jump;
    assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
    assign bus.ex_alu_ctrl   = r_ex.alu_ctrl;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    // Only stalls that actually hold a live instruction are counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.stall && !bus.flush && r_ex.valid && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (bus.flush && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mr, mw, as, br, jp;
        logic [1:0]  m2r;
        logic [3:0]  alu;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_WIDTH(32)) bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    id_ex_stage #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
    id_ex_stage #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    // stimulus state
    ent_t        in;
    logic        stall, flush, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    assign bus.stall         = stall;
    assign bus.flush         = flush;
    assign bus.id_valid      = in.valid;
    assign bus.id_pc         = in.pc;
    assign bus.id_rd1        = in.rd1;
    assign bus.id_rd2        = in.rd2;
    assign bus.id_imm        = in.imm;
    assign bus.id_rs1        = in.rs1;
    assign bus.id_rs2        = in.rs2;
    assign bus.id_rd         = in.rd;
    assign bus.id_reg_write  = in.rw;
    assign bus.id_mem_read   = in.mr;
    assign bus.id_mem_write  = in.mw;
    assign bus.id_alu_src    = in.as;
    assign bus.id_branch     = in.br;
    assign bus.id_jump       = in.jp;
    assign bus.id_mem_to_reg = in.m2r;
    assign bus.id_alu_ctrl   = in.alu;
    assign bus.wb_reg_write  = wb_we;
    assign bus.wb_rd         = wb_rd;
    assign bus.wb_data       = wb_data;

    int checks = 0;
    int errors = 0;
    ent_t exp_e;   // reference model contents of the stage

    function automatic ent_t observed();
        ent_t o;
        o.valid = bus.ex_valid;   o.pc  = bus.ex_pc;   o.rd1 = bus.ex_rd1;
        o.rd2   = bus.ex_rd2;     o.imm = bus.ex_imm;  o.rs1 = bus.ex_rs1;
        o.rs2   = bus.ex_rs2;     o.rd  = bus.ex_rd;   o.rw  = bus.ex_reg_write;
        o.mr    = bus.ex_mem_read; o.mw = bus.ex_mem_write; o.as = bus.ex_alu_src;
        o.br    = bus.ex_branch;  o.jp  = bus.ex_jump; o.m2r = bus.ex_mem_to_reg;
        o.alu   = bus.ex_alu_ctrl;
        return o;
    endfunction

    // Behavioural rule set: what the stage should hold after one edge.
    function automatic ent_t model_next(ent_t cur, ent_t i, logic r, logic s, logic f,
                                        logic we, logic [4:0] wrd, logic [31:0] wd);
        ent_t n;
        if (!r || f) return '0;
        if (s) return cur;
        n = i;
        if (!i.valid) begin
            n.rw = 0; n.mr = 0; n.mw = 0; n.as = 0; n.br = 0; n.jp = 0;
            n.m2r = 0; n.alu = 0;
        end
        if (we && wrd != 0 && wrd == i.rs1) n.rd1 = wd;
        if (we && wrd != 0 && wrd == i.rs2) n.rd2 = wd;
        return n;
    endfunction

    // Advance one edge, updating the model; returns #1 after the edge.
    task automatic tick();
        exp_e = model_next(exp_e, in, rst_n, stall, flush, wb_we, wb_rd, wb_data);
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        e.valid = ($urandom_range(0, 9) < 8);
        e.rs1 = 5'($urandom_range(0, 7));
        e.rs2 = 5'($urandom_range(0, 7));
        return e;
    endfunction

    task automatic idle_inputs();
        in = '0; stall = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1; in = rand_ent(); in.valid = 1; in.rw = 1;
        tick();
        rst_n = 0; stall = 1; in.valid = 1; in.pc = 32'h100; in.mw = 1; in.jp = 1;
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h0 || bus.ex_reg_write !== 1'b0 ||
            bus.ex_mem_write !== 1'b0 || bus.ex_jump !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b pc=%h rw=%b mw=%b jp=%b, want all 0",
                     bus.ex_valid, bus.ex_pc, bus.ex_reg_write, bus.ex_mem_write, bus.ex_jump);
        end
        checks++;
        if (observed() !== ent_t'(0)) begin
            errors++;
            $display("FAIL reset_all: got %h want 0", observed());
        end
        rst_n = 1; stall = 0; exp_e = '0;
    endtask

    task automatic test_load_stall();
        idle_inputs();
        in = rand_ent(); in.valid = 1; in.pc = 32'h40; in.rd1 = 32'h11; in.rs1 = 3;
        tick();
        checks++;
        if (bus.ex_pc !== 32'h40 || bus.ex_rd1 !== 32'h11 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL load: got pc=%h rd1=%h v=%b want 40 11 1", bus.ex_pc, bus.ex_rd1, bus.ex_valid);
        end
        stall = 1; in.pc = 32'h44; in.rd1 = 32'h22;
        // write-back to the held source must not patch the held entry
        wb_we = 1; wb_rd = 3; wb_data = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.ex_pc !== 32'h40 || bus.ex_rd1 !== 32'h11) begin
                errors++;
                $display("FAIL stall_hold%0d: got pc=%h rd1=%h want 40 11", k, bus.ex_pc, bus.ex_rd1);
            end
        end
        stall = 0; wb_we = 0;
        tick();
        checks++;
        if (bus.ex_pc !== 32'h44 || bus.ex_rd1 !== 32'h22) begin
            errors++;
            $display("FAIL stall_release: got pc=%h rd1=%h want 44 22", bus.ex_pc, bus.ex_rd1);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        in = rand_ent(); in.valid = 1; in.rw = 1;
        tick();
        stall = 1; flush = 1; in.rw = 1; in.pc = 32'h1234;
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_pc !== 32'h0) begin
            errors++;
            $display("FAIL flush_stall: got v=%b rw=%b pc=%h want 0 0 0",
                     bus.ex_valid, bus.ex_reg_write, bus.ex_pc);
        end
        checks++;
        if (observed() !== ent_t'(0)) begin
            errors++;
            $display("FAIL flush_bubble: got %h want 0", observed());
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        in = rand_ent(); in.valid = 1; in.rs1 = 5; in.rs2 = 5;
        in.rd1 = 32'h1; in.rd2 = 32'h1;
        wb_we = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (bus.ex_rd1 !== 32'hDEAD_BEEF || bus.ex_rd2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_hit: got rd1=%h rd2=%h want deadbeef", bus.ex_rd1, bus.ex_rd2);
        end
        wb_rd = 0; in.rs1 = 0; in.rs2 = 9;
        tick();
        checks++;
        if (bus.ex_rd1 !== 32'h1 || bus.ex_rd2 !== 32'h1) begin
            errors++;
            $display("FAIL bypass_x0: got rd1=%h rd2=%h want 1 1", bus.ex_rd1, bus.ex_rd2);
        end
        // only rs2 matches
        wb_rd = 9;
        tick();
        checks++;
        if (bus.ex_rd1 !== 32'h1 || bus.ex_rd2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL bypass_rs2: got rd1=%h rd2=%h want 1 deadbeef", bus.ex_rd1, bus.ex_rd2);
        end
    endtask

    task automatic test_invalid();
        idle_inputs();
        in = rand_ent(); in.valid = 0; in.mw = 1; in.rw = 1; in.pc = 32'h80;
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_mem_write !== 1'b0 || bus.ex_reg_write !== 1'b0 ||
            bus.ex_pc !== 32'h80) begin
            errors++;
            $display("FAIL invalid_load: got v=%b mw=%b rw=%b pc=%h want 0 0 0 80",
                     bus.ex_valid, bus.ex_mem_write, bus.ex_reg_write, bus.ex_pc);
        end
        checks++;
        if (observed() !== exp_e) begin
            errors++;
            $display("FAIL invalid_fields: got %h want %h", observed(), exp_e);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            in      = rand_ent();
            rst_n   = ($urandom_range(0, 39) != 0);
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            wb_we   = $urandom_range(0, 1);
            wb_rd   = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            tick();
            checks++;
            if (observed() !== exp_e) begin
                errors++;
                $display("FAIL random[%0d]: got %h want %h", k, observed(), exp_e);
            end
            checks++;
            if (!bus.ex_valid && (bus.ex_reg_write || bus.ex_mem_write || bus.ex_mem_read ||
                                  bus.ex_branch || bus.ex_jump)) begin
                errors++;
                $display("FAIL random_ctrl_bubble[%0d]: got ctrl active with valid=0, want 0", k);
            end
        end
        rst_n = 1;
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_counters();
        idle_inputs();
        rst_n = 0; tick(); rst_n = 1;
        in = rand_ent(); in.valid = 1;
        tick();
        stall = 1;
        repeat (4) tick();
        stall = 0; flush = 1;
        repeat (2) tick();
        flush = 0; stall = 1;   // bubble held: not counted
        repeat (3) tick();
        stall = 0;
        checks++;
        if (stall_cnt !== 32'd4 || flush_cnt !== 32'd2) begin
            errors++;
            $display("FAIL counters: got stall=%0d flush=%0d want 4 2", stall_cnt, flush_cnt);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst_n = 0;
        exp_e = '0;
        tick();
        rst_n = 1;
        test_reset();
        test_load_stall();
        test_flush();
        test_bypass();
        test_invalid();
        test_random();
`ifdef ID_EX_PERF_CNT_EN
        test_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
